// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: request and response handshake bundle for div_seq_ctrl.
//   Request  : in_valid, in_ready, in_a (dividend), in_b (divisor), in_tag.
//   Response : out_valid, out_ready, out_q, out_r, out_tag, out_dz (divide by zero),
//              out_to (watchdog timeout).
//   Modports : slave  - the sequencer (accepts requests, produces responses).
//              master - the client (issues requests, consumes responses).
interface div_seq_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic [TAG_W-1:0] out_tag;
  logic             out_dz;
  logic             out_to;

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_q, out_r, out_tag, out_dz, out_to
  );

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_tag, out_dz, out_to
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: request/response sequencer around a WIDTH-bit iterative divider.
// Accepts one operand pair at a time, launches the divider with a level start, captures
// quotient/remainder on the divider's single completion cycle and holds the response until
// it is consumed. Divide-by-zero is answered without touching the divider; a watchdog
// aborts the operation if the divider never completes.
//
// Ports:
//   clk, reset  - clock (rising edge), asynchronous active-high reset.
//   req         - div_seq_ctrl_if.slave request/response handshake.
//   div_start   - divider start, held high for the whole operation.
//   div_a/div_b - divider operands (held stable from the operand registers).
//   div_d/div_r - divider quotient/remainder, valid on the cycle div_ok returns high.
//   div_ok      - divider not active.
//   busy        - high whenever the sequencer is not idle.
//
// Optional build macro DIV_SEQ_SIGNED_EN: two's complement operands. The divider sees
// magnitudes and the signs are fixed up combinationally at capture; most-negative / -1 is
// answered directly without launching the divider.
module div_seq_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset,
  div_seq_ctrl_if.slave    req,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_d,
  input  logic [WIDTH-1:0] div_r,
  input  logic             div_ok,
  output logic             busy
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StBusy, StDone} state_e;

  state_e           state_q;
  logic [WdW-1:0]   wd_q;
  logic [WIDTH-1:0] a_q, b_q, q_q, r_q;
  logic [TAG_W-1:0] tag_q;
  logic             dz_q, to_q, in_ready_q, out_valid_q, div_start_q, busy_q;

  // Operand/result shaping; identity in the unsigned build.
  logic [WIDTH-1:0] a_mag, b_mag, cap_q, cap_r, dz_quot;

`ifdef DIV_SEQ_SIGNED_EN
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};
  logic a_neg, b_neg, min_div_neg1, neg_q_q, neg_r_q;

  assign a_neg        = req.in_a[WIDTH-1];
  assign b_neg        = req.in_b[WIDTH-1];
  assign a_mag        = a_neg ? -req.in_a : req.in_a;
  assign b_mag        = b_neg ? -req.in_b : req.in_b;
  assign min_div_neg1 = (req.in_a == MostNeg) && (req.in_b == '1);
  // Quotient sign follows sign mismatch; remainder follows the dividend.
  assign cap_q        = neg_q_q ? -div_d : div_d;
  assign cap_r        = neg_r_q ? -div_r : div_r;
  assign dz_quot      = a_neg ? WIDTH'(1) : '1;
`else
  assign a_mag   = req.in_a;
  assign b_mag   = req.in_b;
  assign cap_q   = div_d;
  assign cap_r   = div_r;
  assign dz_quot = '1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      wd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      tag_q       <= '0;
      dz_q        <= 1'b0;
      to_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      div_start_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DIV_SEQ_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req.in_valid && in_ready_q) begin
            tag_q      <= req.in_tag;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (req.in_b == '0) begin
              q_q         <= dz_quot;
              r_q         <= req.in_a;
              dz_q        <= 1'b1;
              to_q        <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
`ifdef DIV_SEQ_SIGNED_EN
            end else if (min_div_neg1) begin
              // Only overflowing case; answer it without the divider.
              q_q         <= MostNeg;
              r_q         <= '0;
              dz_q        <= 1'b0;
              to_q        <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
`endif
            end else begin
              a_q         <= a_mag;
              b_q         <= b_mag;
              div_start_q <= 1'b1;
              state_q     <= StLoad;
`ifdef DIV_SEQ_SIGNED_EN
              neg_q_q     <= a_neg ^ b_neg;
              neg_r_q     <= a_neg;
`endif
            end
          end
        end
        StLoad: begin
          // div_ok stays high through the divider's operand-load cycle.
          if (!div_ok) begin
            wd_q    <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          // Results exist only on this cycle: the divider re-arms or clears right after.
          if (div_ok) begin
            q_q         <= cap_q;
            r_q         <= cap_r;
            dz_q        <= 1'b0;
            to_q        <= 1'b0;
            div_start_q <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else if (wd_q == WdMax) begin
            q_q         <= '0;
            r_q         <= '0;
            dz_q        <= 1'b0;
            to_q        <= 1'b1;
            div_start_q <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StDone: begin
          if (req.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req.in_ready  = in_ready_q;
  assign req.out_valid = out_valid_q;
  assign req.out_q     = q_q;
  assign req.out_r     = r_q;
  assign req.out_tag   = tag_q;
  assign req.out_dz    = dz_q;
  assign req.out_to    = to_q;
  assign div_start     = div_start_q;
  assign div_a         = a_q;
  assign div_b         = b_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed bench for div_seq_ctrl with a behavioural iterative divider.
// Divider model: with start high, one load cycle (ok=1), WIDTH busy cycles (ok=0), then one
// completion cycle (ok=1, results valid) after which it re-arms; start low clears it.
// Outside the completion cycle div_d/div_r carry a junk pattern.
module tb_div_seq_ctrl;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_seq_ctrl_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  logic             div_start, div_ok, busy;
  logic [WIDTH-1:0] div_a, div_b, div_d, div_r;

  div_seq_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (bus),
    .div_start(div_start),
    .div_a    (div_a),
    .div_b    (div_b),
    .div_d    (div_d),
    .div_r    (div_r),
    .div_ok   (div_ok),
    .busy     (busy)
  );

  // Divider model.
  logic [5:0] m_cnt = '0;
  logic       hang  = 1'b0;
  localparam logic [5:0] MDone = 6'(WIDTH + 1);

  always @(posedge clk) begin
    if (!div_start)                  m_cnt <= '0;
    else if (m_cnt == MDone)         m_cnt <= '0;
    else if (hang && m_cnt == 6'd1)  m_cnt <= 6'd1;
    else                             m_cnt <= m_cnt + 6'd1;
  end

  assign div_ok = (m_cnt == 6'd0) || (m_cnt == MDone);
  assign div_d  = (m_cnt == MDone && div_b != 0) ? div_a / div_b : 32'hDEAD_BEEF;
  assign div_r  = (m_cnt == MDone && div_b != 0) ? div_a % div_b : 32'hDEAD_BEEF;

  int   checks = 0;
  int   errors = 0;
  logic st_all, st_any;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; returns idle cycles waited for in_ready and the latency, counted
  // with the acceptance edge as 1. Leaves the bench at the first sample with out_valid=1.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                      output int waits, output int lat);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    waits        = 0;
    while (!bus.in_ready && waits < 100) begin
      tick();
      waits++;
    end
    tick();
    bus.in_valid = 1'b0;
    lat    = 1;
    st_all = 1'b1;
    st_any = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      st_all = st_all & div_start;
      st_any = st_any | div_start;
      tick();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  int   w, lat;
  logic stable;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_div_start", 64'(div_start), 64'd0);
    check("rst_out_q", 64'(bus.out_q), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // 100 / 7, tag 3.
    send(32'd100, 32'd7, 4'd3, w, lat);
    check("t1_lat", 64'(lat), 64'd35);
    check("t1_q", 64'(bus.out_q), 64'd14);
    check("t1_r", 64'(bus.out_r), 64'd2);
    check("t1_tag", 64'(bus.out_tag), 64'd3);
    check("t1_dz", 64'(bus.out_dz), 64'd0);
    check("t1_to", 64'(bus.out_to), 64'd0);
    check("t1_start_hold", 64'(st_all), 64'd1);
    check("t1_div_a", 64'(div_a), 64'd100);
    check("t1_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("t1_valid_drop", 64'(bus.out_valid), 64'd0);

    // Divide by zero.
    send(32'hFFFF_FFFF, 32'd0, 4'd5, w, lat);
    check("t2_lat", 64'(lat), 64'd1);
`ifdef DIV_SEQ_SIGNED_EN
    check("t2_q", 64'(bus.out_q), 64'd1);
`else
    check("t2_q", 64'(bus.out_q), 64'hFFFF_FFFF);
`endif
    check("t2_r", 64'(bus.out_r), 64'hFFFF_FFFF);
    check("t2_dz", 64'(bus.out_dz), 64'd1);
    check("t2_tag", 64'(bus.out_tag), 64'd5);
    check("t2_no_start", 64'(st_any | div_start), 64'd0);
    tick();

    // Back-pressure, then back-to-back request.
    bus.out_ready = 1'b0;
    send(32'd1000, 32'd10, 4'd6, w, lat);
    check("t3_lat", 64'(lat), 64'd35);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      stable = stable & (bus.out_q == 32'd100) & (bus.out_r == 32'd0) & bus.out_valid
             & !bus.in_ready;
    end
    check("t3_hold", 64'(stable), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    check("t3_valid_drop", 64'(bus.out_valid), 64'd0);
    check("t3_q_held", 64'(bus.out_q), 64'd100);
    send(32'd9, 32'd4, 4'd7, w, lat);
    check("t3b_waits", 64'(w), 64'd0);
    check("t3b_q", 64'(bus.out_q), 64'd2);
    check("t3b_r", 64'(bus.out_r), 64'd1);
    check("t3b_tag", 64'(bus.out_tag), 64'd7);
    tick();

    // Hung divider.
    hang = 1'b1;
    send(32'd123, 32'd4, 4'd8, w, lat);
    check("t4_lat", 64'(lat), 64'(TIMEOUT + 3));
    check("t4_to", 64'(bus.out_to), 64'd1);
    check("t4_q", 64'(bus.out_q), 64'd0);
    check("t4_r", 64'(bus.out_r), 64'd0);
    tick();
    hang = 1'b0;
    send(32'd6, 32'd3, 4'd9, w, lat);
    check("t4b_q", 64'(bus.out_q), 64'd2);
    check("t4b_r", 64'(bus.out_r), 64'd0);
    check("t4b_to", 64'(bus.out_to), 64'd0);
    tick();

    // Reset in mid-operation.
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd50;
    bus.in_b     = 32'd5;
    bus.in_tag   = 4'd2;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    check("t5_busy_pre", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_div_start", 64'(div_start), 64'd0);
    check("t5_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    send(32'd50, 32'd5, 4'd1, w, lat);
    check("t5b_lat", 64'(lat), 64'd35);
    check("t5b_q", 64'(bus.out_q), 64'd10);
    check("t5b_r", 64'(bus.out_r), 64'd0);
    tick();

`ifdef DIV_SEQ_SIGNED_EN
    send(-32'sd7, 32'd2, 4'd4, w, lat);
    check("s1_q", 64'(bus.out_q), 64'hFFFF_FFFD);
    check("s1_r", 64'(bus.out_r), 64'hFFFF_FFFF);
    check("s1_lat", 64'(lat), 64'd35);
    tick();
    send(32'd7, -32'sd2, 4'd4, w, lat);
    check("s2_q", 64'(bus.out_q), 64'hFFFF_FFFD);
    check("s2_r", 64'(bus.out_r), 64'd1);
    tick();
    send(32'h8000_0000, 32'hFFFF_FFFF, 4'd4, w, lat);
    check("s3_lat", 64'(lat), 64'd1);
    check("s3_q", 64'(bus.out_q), 64'h8000_0000);
    check("s3_r", 64'(bus.out_r), 64'd0);
    check("s3_no_start", 64'(st_any | div_start), 64'd0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Request/response sequencer wrapped around the 32-bit iterative divider (level-sensitive start, ok/err outputs, registers cleared while start is low).
- Accepts operand pairs over a valid/ready handshake and launches the divider.
- Captures quotient and remainder on the single completion cycle, then holds them on a valid/ready output port.
- Short-circuits divide-by-zero, and watchdogs the divider against hangs.

Parameters:
- WIDTH, 32, operand/result width; must equal divider width.
- TAG_W, 4, width of the opaque request tag carried to the response.
- TIMEOUT, 40, maximum cycles in BUSY before an abort (must be > WIDTH+2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_a  in  WIDTH  dividend.
- in_b  in  WIDTH  divisor.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  response valid; held until out_ready.
- out_ready  in  1  response consumed when out_valid & out_ready.
- out_q  out  WIDTH  quotient.
- out_r  out  WIDTH  remainder.
- out_tag  out  TAG_W  tag of the request.
- out_dz  out  1  divide-by-zero flag.
- out_to  out  1  timeout flag.
- div_start  out  1  divider start (level, held for the whole operation).
- div_a  out  WIDTH  divider A.
- div_b  out  WIDTH  divider B.
- div_d  in  WIDTH  divider quotient.
- div_r  in  WIDTH  divider remainder.
- div_ok  in  1  divider ok (high = not active).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async) values:
  - All outputs 0 except in_ready=1.
  - State IDLE; watchdog counter 0; operand, result and tag registers 0.
- States: IDLE, LOAD, BUSY, DONE.
- IDLE:
  - in_ready=1, div_start=0.
  - On accept with in_b!=0: register a, b and tag; go to LOAD.
  - On accept with in_b==0: do not touch the divider. Set out_q all-ones, out_r=in_a, out_dz=1, out_to=0, latch the tag; go to DONE. Response is valid the cycle after acceptance.
- LOAD:
  - div_start=1; div_a/div_b driven from the operand registers (stable for the whole operation).
  - Divider spends its first start cycle with ok=1 (operand load).
  - Wait for div_ok==0, then go to BUSY and clear the watchdog.
- BUSY:
  - div_start=1; watchdog increments each cycle.
  - When div_ok==1: capture div_d→out_q and div_r→out_r in that same cycle, with out_dz=0 and out_to=0. Go to DONE.
  - The capture is mandatory on that cycle: the divider re-arms if start stays high, and clears if start drops.
  - If the watchdog reaches TIMEOUT-1 without div_ok: go to DONE with out_to=1, out_q=0, out_r=0.
- DONE:
  - div_start=0, which clears the divider. out_valid=1, in_ready=0.
  - Outputs are frozen while out_ready=0.
  - On out_valid & out_ready: go to IDLE. out_valid falls next cycle; out_q, out_r, out_tag and the flags hold their last value.
- Throughput:
  - No overlap: one request in flight; in_ready is low in LOAD, BUSY and DONE.
  - Nominal latency from acceptance to out_valid: 1 (to LOAD) + 1 (load cycle) + WIDTH (iterations) + 1 (capture) = 35 cycles at WIDTH=32.
  - The bench checks the exact value measured against the divider model and must see it constant across operands.
- Back-to-back: a new request may be accepted the cycle after the DONE handshake, i.e. one IDLE cycle minimum.
- Reset mid-operation:
  - Immediate return to IDLE; div_start=0, so the divider is cleared too.
  - Any pending response is discarded; out_valid=0.
- Widths: no arithmetic beyond the watchdog, which is clog2(TIMEOUT) bits and saturates at TIMEOUT-1.

Optional Feature:
- Macro: DIV_SEQ_SIGNED_EN.
- When defined:
  - Operands are two's complement. div_a/div_b carry their magnitudes.
  - Quotient is negated when operand signs differ. Remainder takes the dividend's sign.
  - Special case: most-negative / -1 returns out_q=0x80000000, out_r=0, no divider launch, 1-cycle latency.
  - Divide-by-zero: out_q = all-ones if the dividend is ≥0, else 1; out_r=in_a.
  - Sign fix-up is applied combinationally at capture; latency is unchanged.
- When undefined: pure unsigned operation as above; no sign logic is synthesised.

Test Plan:
- 100/7, tag 3, out_ready=1 → out_q=14, out_r=2, out_tag=3, out_dz=0, out_to=0. out_valid exactly 35 cycles after acceptance; div_start high the whole interval.
- 0xFFFFFFFF/0, tag 5 → out_valid the next cycle, out_q=0xFFFFFFFF, out_r=0xFFFFFFFF, out_dz=1; div_start never asserted.
- 1000/10 with out_ready=0 for 20 cycles after out_valid → out_q=100, out_r=0 stable throughout, in_ready=0. Then 9/4 accepted 1 cycle after the handshake → q=2, r=1.
- Divider model holds div_ok=0 forever → out_to=1, out_q=0 after TIMEOUT cycles in BUSY; next request 6/3 → q=2, r=0.
- Assert reset 10 cycles into 50/5 → busy=0, div_start=0, out_valid=0, in_ready=1 asynchronously. Subsequent 50/5 → q=10, r=0.
- With DIV_SEQ_SIGNED_EN defined:
  - -7/2 → q=-3 (0xFFFFFFFD), r=-1.
  - 7/-2 → q=-3, r=1.
  - 0x80000000/-1 → q=0x80000000, r=0 with 1-cycle latency.
